// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types, widths and requantizer for the accumulator store path
package mm_pkg;

  localparam int ACC_ADDR_W = 11;
  localparam int ACC_DATA_W = 32;

  typedef enum logic [1:0] {
    W8  = 2'd0,
    W16 = 2'd1,
    W32 = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } st_state_e;

  // Arithmetic right shift, then clamp to the signed range of the selected
  // output width; the result stays sign-extended in 32 bits.  Code 3 behaves as 32b.
  function automatic logic [ACC_DATA_W-1:0] requant(
    input logic [ACC_DATA_W-1:0] data,
    input logic [4:0]            shift,
    input logic [1:0]            width
  );
    logic signed [ACC_DATA_W-1:0] s;
    s = $signed(data) >>> shift;
    if (width == W8) begin
      if (s > 32'sd127)       s = 32'sd127;
      else if (s < -32'sd128) s = -32'sd128;
    end else if (width == W16) begin
      if (s > 32'sd32767)       s = 32'sd32767;
      else if (s < -32'sd32768) s = -32'sd32768;
    end
    return $unsigned(s);
  endfunction

endpackage

// File: rtl/mm_st_fifo.sv
// rtl/mm_st_fifo.sv - small synchronous FIFO holding requantized words plus last flag
module mm_st_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 33,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage array; no reset needed since count gates visibility of entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/mm_acc_store.sv
// rtl/mm_acc_store.sv - drains one accumulator bank, requantizes and streams it to the store path
module mm_acc_store
  import mm_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_start,
  input  logic [ACC_ADDR_W-1:0] st_base_addr,
  input  logic [ACC_ADDR_W-1:0] st_len,
  input  logic                  st_bank,
  input  logic [1:0]            st_width,
  input  logic [4:0]            st_shift,
  output logic                  st_rd_en,
  output logic [ACC_ADDR_W-1:0] st_rd_addr,
  output logic                  st_rd_bank,
  input  logic [ACC_DATA_W-1:0] st_rd_data,
  output logic [ACC_DATA_W-1:0] st_data,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic                  st_last,
  output logic                  st_busy,
  output logic                  st_done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  st_state_e             state;
  logic [ACC_ADDR_W:0]   remaining;
  logic [1:0]            width_q;
  logic [4:0]            shift_q;
  logic [RD_LAT-1:0]     pipe_v;
  logic [RD_LAT-1:0]     pipe_last;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           used;
  logic [ACC_DATA_W:0]   fifo_dout;
  logic                  fifo_pop;
  logic                  ret_valid;

  // Outstanding reads still travelling through the read-latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe_v[i]);
  end

  // A read may only go out when the FIFO is guaranteed a slot for its data.
  assign used      = {1'b0, fifo_count} + {1'b0, inflight};
  assign st_rd_en  = (state == S_READ) && (used < (CW + 1)'(FIFO_DEPTH));
  assign ret_valid = pipe_v[RD_LAT-1];

  // Command sequencing: latch the command, walk the addresses, then wait for the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      st_rd_addr <= '0;
      st_rd_bank <= 1'b0;
      width_q    <= '0;
      shift_q    <= '0;
      remaining  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (st_start) begin
            st_rd_addr <= st_base_addr;
            st_rd_bank <= st_bank;
            width_q    <= st_width;
            shift_q    <= st_shift;
            remaining  <= {1'b0, st_len} + (ACC_ADDR_W + 1)'(1);
            state      <= S_READ;
          end
        end
        S_READ: begin
          if (st_rd_en) begin
            st_rd_addr <= st_rd_addr + ACC_ADDR_W'(1);
            remaining  <= remaining - (ACC_ADDR_W + 1)'(1);
            if (remaining == (ACC_ADDR_W + 1)'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (inflight == '0 && fifo_count == '0) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-latency tracker: marks which cycles carry returning data and whether it is the final word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      pipe_v[0]    <= st_rd_en;
      pipe_last[0] <= st_rd_en && (remaining == (ACC_ADDR_W + 1)'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  assign fifo_pop = st_valid && st_ready;

  mm_st_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ACC_DATA_W + 1),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_valid),
    .din   ({pipe_last[RD_LAT-1], requant(st_rd_data, shift_q, width_q)}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign st_valid = (fifo_count != '0);
  assign st_data  = st_valid ? fifo_dout[ACC_DATA_W-1:0] : '0;
  assign st_last  = st_valid && fifo_dout[ACC_DATA_W];
  assign st_busy  = (state == S_READ) || (state == S_DRAIN);
  assign st_done  = (state == S_DONE);

endmodule

// File: tb/tb_mm_acc_store.sv
// tb/tb_mm_acc_store.sv - self-checking bench for mm_acc_store against a behavioural model
module tb_mm_acc_store;
  import mm_pkg::*;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = RD_LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_start = 1'b0;
  logic [10:0] st_base_addr = '0;
  logic [10:0] st_len = '0;
  logic        st_bank = 1'b0;
  logic [1:0]  st_width = '0;
  logic [4:0]  st_shift = '0;
  logic        st_rd_en;
  logic [10:0] st_rd_addr;
  logic        st_rd_bank;
  logic [31:0] st_rd_data = '0;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready = 1'b1;
  logic        st_last;
  logic        st_busy;
  logic        st_done;

  mm_acc_store #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .st_start(st_start), .st_base_addr(st_base_addr),
    .st_len(st_len), .st_bank(st_bank), .st_width(st_width), .st_shift(st_shift),
    .st_rd_en(st_rd_en), .st_rd_addr(st_rd_addr), .st_rd_bank(st_rd_bank),
    .st_rd_data(st_rd_data), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_last(st_last), .st_busy(st_busy), .st_done(st_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int issued = 0;
  int accepted = 0;
  int first_rd = -1;
  int first_val = -1;
  int start_cyc = 0;
  int rd_cyc_q[$];
  logic [31:0] mem_m [2][2048];
  logic [32:0] exp_q[$];
  logic [11:0] exp_addr_q[$];
  bit          held = 0;
  logic [31:0] held_d;
  logic        held_l;
  bit          cap_v = 0;
  logic        cap_b;
  logic [10:0] cap_a;
  bit          ln_v [RD_LAT];
  logic        ln_b [RD_LAT];
  logic [10:0] ln_a [RD_LAT];

  always @(posedge clk) cyc++;

  function automatic logic [31:0] rq_model(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] w);
    longint v, lo, hi;
    int bits;
    bits = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
    v  = longint'($signed(d));
    v  = v >>> sh;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -(longint'(1) <<< (bits - 1));
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Accumulator memory model: answers each read RD_LAT cycles later; drives st_ready.
  always @(negedge clk) begin
    cap_v = st_rd_en;
    cap_b = st_rd_bank;
    cap_a = st_rd_addr;
  end

  always @(posedge clk) begin
    #1;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      ln_v[i] = ln_v[i-1];
      ln_b[i] = ln_b[i-1];
      ln_a[i] = ln_a[i-1];
    end
    ln_v[0] = cap_v;
    ln_b[0] = cap_b;
    ln_a[0] = cap_a;
    st_rd_data = ln_v[RD_LAT-1] ? mem_m[ln_b[RD_LAT-1]][ln_a[RD_LAT-1]] : $urandom;
    case (ready_mode)
      0:       st_ready = 1'b1;
      1:       st_ready = (cyc % 3 == 0);
      2:       st_ready = 1'($urandom_range(0, 1));
      default: st_ready = 1'b0;
    endcase
  end

  // Stream monitor: read addresses, credit limit, output order/data, stalls, done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (st_rd_en) begin
        rd_cyc_q.push_back(cyc);
        if (first_rd < 0) first_rd = cyc;
        issued++;
        tests++;
        if (exp_addr_q.size() == 0) begin
          assert (0) else begin fails++; $error("FAIL rd_unexpected: got %0h want none", st_rd_addr); end
        end else begin
          logic [11:0] ea;
          ea = exp_addr_q.pop_front();
          assert ({st_rd_bank, st_rd_addr} === ea) else begin
            fails++; $error("FAIL rd_addr: got %0h want %0h", {st_rd_bank, st_rd_addr}, ea);
          end
        end
        tests++;
        assert (issued - accepted <= FIFO_DEPTH) else begin
          fails++; $error("FAIL credit: got %0d want <=%0d", issued - accepted, FIFO_DEPTH);
        end
      end
      if (held) begin
        tests++;
        assert (st_valid === 1'b1 && st_data === held_d && st_last === held_l) else begin
          fails++; $error("FAIL stall_hold: got %0h/%0b want %0h/%0b", st_data, st_last, held_d, held_l);
        end
      end
      held   = st_valid && !st_ready;
      held_d = st_data;
      held_l = st_last;
      if (st_valid && st_ready) begin
        if (first_val < 0) first_val = cyc;
        accepted++;
        tests++;
        if (exp_q.size() == 0) begin
          assert (0) else begin fails++; $error("FAIL word_unexpected: got %0h want none", st_data); end
        end else begin
          logic [32:0] ew;
          ew = exp_q.pop_front();
          assert ({st_last, st_data} === ew) else begin
            fails++; $error("FAIL word: got %0h want %0h", {st_last, st_data}, ew);
          end
        end
      end
      if (st_done) begin
        done_cnt++;
        tests++;
        assert (st_busy === 1'b0 && exp_q.size() == 0) else begin
          fails++; $error("FAIL done_state: got busy=%0b left=%0d want 0/0", st_busy, exp_q.size());
        end
      end
    end
  end

  task automatic cmd(input logic [10:0] base, input logic [10:0] len, input logic bank,
                     input logic [1:0] w, input logic [4:0] sh, input bit use_model);
    for (int i = 0; i <= int'(len); i++) begin
      logic [10:0] a;
      a = 11'((int'(base) + i) % 2048);
      exp_addr_q.push_back({bank, a});
      if (use_model) exp_q.push_back({i == int'(len), rq_model(mem_m[bank][a], sh, w)});
    end
    st_base_addr = base;
    st_len       = len;
    st_bank      = bank;
    st_width     = w;
    st_shift     = sh;
    st_start     = 1'b1;
    start_cyc    = cyc;
    @(posedge clk); #1;
    st_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, 64'(done_cnt), 64'(d0 + 1));
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_once"}, 64'(done_cnt), 64'(d0 + 1));
    chk({tag, "_drained"}, 64'(exp_q.size() + exp_addr_q.size()), 64'd0);
    chk({tag, "_idle"}, {63'd0, st_busy}, 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, {63'd0, st_rd_en}, 64'd0);
    chk({tag, "_rd_addr"}, {53'd0, st_rd_addr}, 64'd0);
    chk({tag, "_rd_bank"}, {63'd0, st_rd_bank}, 64'd0);
    chk({tag, "_valid"}, {63'd0, st_valid}, 64'd0);
    chk({tag, "_data"}, {32'd0, st_data}, 64'd0);
    chk({tag, "_last"}, {63'd0, st_last}, 64'd0);
    chk({tag, "_busy"}, {63'd0, st_busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, st_done}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 2048; a++) mem_m[b][a] = $urandom;
    for (int i = 0; i < RD_LAT; i++) ln_v[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic command: latency, consecutive reads, bank select
    ready_mode = 0;
    first_rd = -1; first_val = -1; rd_cyc_q.delete();
    cmd(11'h010, 11'd3, 1'b1, 2'd2, 5'd0, 1);
    chk("basic_busy_c1", {63'd0, st_busy}, 64'd1);
    wait_done("basic", 100);
    chk("basic_first_rd", 64'(first_rd - start_cyc), 64'd1);
    chk("basic_first_valid", 64'(first_val - start_cyc), 64'(2 + RD_LAT));
    chk("basic_rd_span", 64'(rd_cyc_q[3] - rd_cyc_q[0]), 64'd3);

    // Saturation and shift in 8-bit mode with fixed expected values
    mem_m[0][100] = 32'h0000_1000;
    mem_m[0][101] = 32'hFFFF_F000;
    mem_m[0][102] = 32'h0000_0350;
    exp_q.push_back({1'b0, 32'h0000_007F});
    exp_q.push_back({1'b0, 32'hFFFF_FF80});
    exp_q.push_back({1'b1, 32'h0000_0035});
    cmd(11'd100, 11'd2, 1'b0, 2'd0, 5'd4, 0);
    wait_done("sat8", 100);

    // Backpressure with ready pattern 1,0,0
    ready_mode = 1;
    cmd(11'h200, 11'd7, 1'b0, 2'd1, 5'd3, 1);
    wait_done("bp", 200);

    // Address wrap
    ready_mode = 0;
    cmd(11'd2046, 11'd3, 1'b1, 2'd2, 5'd1, 1);
    wait_done("wrap", 100);

    // Second start while busy is ignored
    ready_mode = 2;
    cmd(11'h300, 11'd9, 1'b0, 2'd0, 5'd2, 1);
    repeat (3) @(posedge clk);
    #1;
    st_base_addr = 11'h700; st_len = 11'd2; st_bank = 1'b1; st_start = 1'b1;
    @(posedge clk); #1;
    st_start = 1'b0;
    wait_done("busy_ign", 300);

    // Randomized commands against the model
    for (int t = 0; t < 8; t++) begin
      ready_mode = t % 3;
      cmd(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 24)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 1);
      wait_done("rand", 400);
    end

    // Reset in the middle of a stalled READ, then a clean command
    ready_mode = 3;
    cmd(11'h050, 11'd50, 1'b1, 2'd2, 5'd0, 1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    exp_addr_q.delete();
    issued = 0; accepted = 0; held = 0;
    rst = 1'b0;
    ready_mode = 0;
    @(posedge clk); #1;
    first_rd = -1;
    cmd(11'h123, 11'd4, 1'b0, 2'd1, 5'd5, 1);
    wait_done("post_rst", 100);
    chk("post_rst_first_rd", 64'(first_rd - start_cyc), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
